// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display scheduler:
// FSM state encoding, 25 MHz timing defaults and a counter sizing helper.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // 1 s of display and 100 ms of blank at 25 MHz
    localparam int DEF_DWELL_CYCLES = 25_000_000;
    localparam int DEF_BLANK_CYCLES = 2_500_000;

    // Bits needed to count 0 .. max(a,b)-1; never less than one bit
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Request/data bundle from the byte producers plus the display-side outputs
// of the scheduler. master = producer/top-level side, slave = scheduler.
interface seg_display_scheduler_if
    import display_pkg::*;
#(
    parameter int N_SRC = 4
);
    localparam int SEL_W = $clog2(N_SRC);

    logic [N_SRC-1:0]   i_req;
    logic [8*N_SRC-1:0] i_data;
    logic               i_hold;
    logic [7:0]         o_byte;
    logic               o_blank;
    logic [N_SRC-1:0]   o_grant;
    logic [SEL_W-1:0]   o_sel;

    modport master (
        output i_req, i_data, i_hold,
        input  o_byte, o_blank, o_grant, o_sel
    );

    modport slave (
        input  i_req, i_data, i_hold,
        output o_byte, o_blank, o_grant, o_sel
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first requesting index after
// `last`, wrapping modulo N. `last` itself is reached only at the end of the
// search, so it wins only when it is the sole requester.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    localparam int SUM_W = SEL_W + 2;

    logic [SEL_W:0]   shamt;
    logic [N-1:0]     rot;
    logic [SUM_W-1:0] off;
    logic [SUM_W-1:0] sum;

    // Rotate so that bit 0 of rot corresponds to index last+1
    assign shamt = (SEL_W+1)'(last) + (SEL_W+1)'(1);
    assign rot   = N'({req, req} >> shamt);

    // Lowest set bit of the rotated vector, mapped back to a source index
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = SUM_W'(k);
            end
        end
        sum = SUM_W'(last) + SUM_W'(1) + off;
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
        idx = sum[SEL_W-1:0];
    end
endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares the two-digit seven-segment display between N_SRC byte
// producers. Active requesters are granted round-robin for DWELL_CYCLES
// each, separated by a BLANK_CYCLES gap so the viewer sees the switch.
// o_byte feeds bin_to_7seg; o_blank forces the segments off upstream.
module seg_display_scheduler
    import display_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input logic                     i_clk,
    input logic                     i_rst,
    seg_display_scheduler_if.slave  bus
);
    localparam int SEL_W = $clog2(N_SRC);
    localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic               blank_q, blank_d;
    logic [7:0]         byte_q, byte_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               others_req;
    logic [7:0]         src_byte [N_SRC];

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign src_byte[k] = bus.i_data[8*k +: 8];
    end

    rr_pick #(
        .N     (N_SRC),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (bus.i_req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // In SHOW, grant_q is the one-hot of the shown source
    assign others_req = |(bus.i_req & ~grant_q);

    // State, counter, round-robin pointer and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= SEL_W'(N_SRC - 1);
            sel_q   <= '0;
            grant_q <= '0;
            blank_q <= 1'b1;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            blank_q <= blank_d;
            byte_q  <= byte_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so all of
    // them change together on the same edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    state_d = ST_SHOW;
                    last_d  = pick_idx;
                end
            end
            ST_SHOW: begin
                // A dropped request beats both hold and dwell expiry
                if (!bus.i_req[last_q]) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (!bus.i_hold) begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (others_req) begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (pick_found) begin
                        state_d = ST_SHOW;
                        last_d  = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        grant_d = '0;
        blank_d = 1'b1;
        byte_d  = 8'h00;
        sel_d   = sel_q;
        if (state_d == ST_SHOW) begin
            grant_d = N_SRC'(1) << last_d;
            blank_d = 1'b0;
            byte_d  = src_byte[last_d];
            sel_d   = last_d;
        end
    end

    assign bus.o_byte  = byte_q;
    assign bus.o_blank = blank_q;
    assign bus.o_grant = grant_q;
    assign bus.o_sel   = sel_q;
endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

- Time-shares the two-digit seven-segment display between up to N_SRC byte producers (counters, switch state, debug values).
- Round-robin among active requesters: each granted source is shown for a fixed dwell time, followed by a blank gap so the viewer sees the switch.
- Drives the byte input of the existing bin_to_7seg converter, plus a blank flag the top level uses to force all segments off (segments are active-low at the pins).

## Interface

- N_SRC, 4: number of requesters, 2..8.
- DWELL_CYCLES, 25_000_000: display time per grant in clocks (1 s at 25 MHz); must be ≥ 1.
- BLANK_CYCLES, 2_500_000: blank gap between grants in clocks; must be ≥ 1.
- i_clk  in  1  system clock. One clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  N_SRC  per-source display request, level-sensitive.
- i_data  in  8*N_SRC  source k byte at bits [8k+7:8k].
- i_hold  in  1  freezes the dwell counter and keeps the current grant.
- o_byte  out  8  byte to bin_to_7seg; reset value 8'h00.
- o_blank  out  1  1 = segments off; reset value 1.
- o_grant  out  N_SRC  one-hot grant; reset value 0.
- o_sel  out  $clog2(N_SRC)  index of the granted or last-granted source; reset value 0.

## Operation

- States:
  - IDLE: no grant, blank.
  - SHOW: one source granted, displayed.
  - GAP: blank between grants.
- Round-robin pointer `last`:
  - Reset value is N_SRC-1, so source 0 wins first.
  - Next pick is the first requesting index after `last`, modulo N_SRC.
  - `last` updates on every entry to SHOW.
- IDLE:
  - Any i_req bit set → SHOW with the picked source.
  - Counter cleared.
- SHOW:
  - o_grant[sel]=1 and o_blank=0.
  - o_byte <= i_data[sel] on every edge, so it tracks live data.
  - Dwell counter increments each cycle unless i_hold=1.
- Leaving SHOW, first matching rule wins:
  - i_req[sel] drops → GAP, even if i_hold=1.
  - Counter reaches DWELL_CYCLES-1 and another source is requesting → GAP.
  - Counter reaches DWELL_CYCLES-1 and only sel is requesting → stay in SHOW, counter restarts at 0.
- GAP:
  - o_grant=0, o_blank=1, o_byte=8'h00.
  - Counter runs for BLANK_CYCLES cycles; i_hold has no effect here.
  - At expiry: if any source is requesting → SHOW with the pick (the previous source is eligible only if it is the sole requester); otherwise → IDLE.
- Counter width is $clog2(max(DWELL_CYCLES, BLANK_CYCLES)). The counter is cleared on every state change and never wraps past its terminal value.

## Timing

- All outputs are registered, and o_byte, o_blank, o_grant and o_sel change on the same edge.
- Request to display latency: i_req rises while in IDLE at cycle t → SHOW, grant and valid o_byte at edge t+1.
- Data latency: an i_data change while granted appears on o_byte 1 cycle later.
- Grant length: with competing requesters and i_hold=0, the grant lasts exactly DWELL_CYCLES cycles, then o_blank is high for exactly BLANK_CYCLES cycles.
- Request drop: i_req[sel] falls at cycle t → o_grant=0 and o_blank=1 at edge t+1.
- Simultaneous events:
  - Dwell expiry coinciding with a request drop is handled as a request drop; the result is the same GAP.
  - A new requester asserting during GAP is considered at GAP expiry.
- Reset: i_rst has priority over everything, including mid-SHOW or mid-GAP. All outputs, the counter and `last` reach their reset values at the next edge.

## Structure

- Package display_pkg holds:
  - the state encoding (IDLE=0, SHOW=1, GAP=2);
  - the default DWELL/BLANK constants for a 25 MHz clock.
- Sub-module rr_pick is purely combinational:
  - Inputs: request vector and `last`.
  - Outputs: found flag and next index.
  - Reused by later arbiters.
- The top level instantiates this block ahead of bin_to_7seg and ORs o_blank into the active-low segment drive.

## Test plan

Bench parameters: N_SRC=4, DWELL_CYCLES=8, BLANK_CYCLES=2.

1. Reset then i_req=4'b0001, i_data[7:0]=8'h2A → after 1 cycle o_grant=0001, o_byte=8'h2A, o_blank=0; grant held indefinitely with no gap.
2. i_req=4'b0101 → source 0 shown 8 cycles, 2 blank cycles with o_byte=00, source 2 shown 8 cycles, then back to source 0.
3. i_req[sel] dropped at cycle 3 of the dwell → blank on the next edge, 2 gap cycles, then the next requester; with none left → IDLE with o_blank=1.
4. i_hold=1 during SHOW with i_req=4'b1111 for 20 cycles → grant unchanged for the whole period; after release the remaining dwell completes before GAP.
5. i_data of the granted source counting 0x00→0xFF each cycle → o_byte follows with 1-cycle lag, including wrap from 0xFF to 0x00.
6. i_rst asserted mid-GAP and mid-SHOW → next edge gives o_grant=0, o_blank=1, o_byte=00, o_sel=0; with i_req=4'b1000 after reset, source 3 is granted 1 cycle later.
